// File: rtl/reaction_game_ctrl.sv
// Reaction-time tester sequencer: random pre-delay, GO lamp, millisecond timing,
// false-start / timeout detection and best-score tracking.
module reaction_game_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11,
    parameter int unsigned MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        led,
    output logic [13:0] ms_count,
    output logic [13:0] best_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam int unsigned MSW = 14;
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned DCW = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS)) + 1;

    localparam logic [15:0]    LFSR_SEED = 16'hACE1;
    localparam logic [MSW-1:0] MS_MAX    = MSW'(MAX_MS);
    localparam logic [MSW-1:0] MS_LAST   = MSW'(MAX_MS - 1);
    localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FAULT  = 3'd4
    } state_e;

    state_e           state_q;
    logic             start_prev_q;
    logic             react_prev_q;
    logic             start_rise_q;
    logic             react_rise_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [DCW-1:0]   delay_cnt_q;
    logic [DCW-1:0]   delay_load_d;
    logic [MSW-1:0]   ms_q;
    logic [MSW-1:0]   ms_inc_d;
    logic [MSW-1:0]   best_q;
    logic             led_q;
    logic             result_valid_q;
    logic             false_start_q;
    logic             timeout_q;
    logic             tick;

    // Fibonacci LFSR, taps 16,14,13,11; the all-zero state is unreachable from the seed.
    assign lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tick         = (presc_q == PRESC_TOP);
    assign presc_d      = tick ? '0 : presc_q + PW'(1);
    assign delay_load_d = DCW'(MIN_DELAY_MS) + DCW'(lfsr_q[DELAY_BITS-1:0]);
    assign ms_inc_d     = ms_q + MSW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            start_prev_q   <= 1'b0;
            react_prev_q   <= 1'b0;
            start_rise_q   <= 1'b0;
            react_rise_q   <= 1'b0;
            lfsr_q         <= LFSR_SEED;
            presc_q        <= '0;
            delay_cnt_q    <= '0;
            ms_q           <= '0;
            best_q         <= MS_MAX;
            led_q          <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            // Registered rising-edge detect: buttons act one cycle after being sampled.
            start_prev_q   <= start_btn;
            react_prev_q   <= react_btn;
            start_rise_q   <= start_btn & ~start_prev_q;
            react_rise_q   <= react_btn & ~react_prev_q;
            lfsr_q         <= lfsr_d;
            presc_q        <= presc_d;
            result_valid_q <= 1'b0;

            case (state_q)
                S_IDLE, S_RESULT, S_FAULT: begin
                    if (start_rise_q) begin
                        state_q       <= S_DELAY;
                        delay_cnt_q   <= delay_load_d;
                        ms_q          <= '0;
                        led_q         <= 1'b0;
                        false_start_q <= 1'b0;
                        timeout_q     <= 1'b0;
                        presc_q       <= '0;
                    end
                end

                S_DELAY: begin
                    // A react during the pre-delay is a false start, even on the expiry cycle.
                    if (react_rise_q) begin
                        state_q       <= S_FAULT;
                        false_start_q <= 1'b1;
                        presc_q       <= '0;
                    end else if (tick) begin
                        if (delay_cnt_q <= DCW'(1)) begin
                            state_q <= S_GO;
                            led_q   <= 1'b1;
                            ms_q    <= '0;
                            presc_q <= '0;
                        end else begin
                            delay_cnt_q <= delay_cnt_q - DCW'(1);
                        end
                    end
                end

                S_GO: begin
                    // React beats a coincident tick, so the captured time is the pre-tick value.
                    if (react_rise_q) begin
                        state_q        <= S_RESULT;
                        led_q          <= 1'b0;
                        result_valid_q <= 1'b1;
                        presc_q        <= '0;
                        if (ms_q < best_q) begin
                            best_q <= ms_q;
                        end
                    end else if (tick) begin
                        if (ms_q >= MS_LAST) begin
                            state_q   <= S_RESULT;
                            ms_q      <= MS_MAX;
                            led_q     <= 1'b0;
                            timeout_q <= 1'b1;
                            presc_q   <= '0;
                        end else begin
                            ms_q <= ms_inc_d;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    led_q   <= 1'b0;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign led          = led_q;
    assign ms_count     = ms_q;
    assign best_ms      = best_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;
    assign state        = state_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Scoreboard bench for reaction_game_ctrl: directed runs push expected output events,
// a negedge monitor pops and compares on every state/flag change or result pulse.
module tb_reaction_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_btn;
    logic        react_btn;
    logic        led;
    logic [13:0] ms_count;
    logic [13:0] best_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic [2:0]  state;

    reaction_game_ctrl #(
        .TICK_DIV    (4),
        .MIN_DELAY_MS(2),
        .DELAY_BITS  (2),
        .MAX_MS      (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .led         (led),
        .ms_count    (ms_count),
        .best_ms     (best_ms),
        .result_valid(result_valid),
        .false_start (false_start),
        .timeout     (timeout),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          at;
        logic [2:0]  st;
        logic        led;
        logic [13:0] ms;
        logic [13:0] best;
        logic        rv;
        logic        fs;
        logic        to;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [13:0] best_m = 14'd20;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference pre-delay random source, used to predict when GO is lit.
    always @(posedge clk) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    logic [2:0] p_st  = 3'h7;
    logic       p_led = 1'b0;
    logic       p_fs  = 1'b0;
    logic       p_to  = 1'b0;
    logic       trig;
    exp_t       e;

    always @(negedge clk) begin
        if (mon_en) begin
            trig = (state !== p_st) || (led !== p_led) || (false_start !== p_fs) ||
                   (timeout !== p_to) || (result_valid === 1'b1);
            p_st  = state;
            p_led = led;
            p_fs  = false_start;
            p_to  = timeout;
            if (trig) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got st=%0d led=%0d ms=%0d best=%0d rv=%0d fs=%0d to=%0d",
                             cyc, state, led, ms_count, best_ms, result_valid, false_start, timeout);
                end else begin
                    e = q.pop_front();
                    if ((e.at != 0 && cyc != e.at) || state !== e.st || led !== e.led ||
                        ms_count !== e.ms || best_ms !== e.best || result_valid !== e.rv ||
                        false_start !== e.fs || timeout !== e.to) begin
                        failures++;
                        $display("FAIL %s: got cyc=%0d st=%0d led=%0d ms=%0d best=%0d rv=%0d fs=%0d to=%0d, want cyc=%0d st=%0d led=%0d ms=%0d best=%0d rv=%0d fs=%0d to=%0d",
                                 e.name, cyc, state, led, ms_count, best_ms, result_valid, false_start, timeout,
                                 e.at, e.st, e.led, e.ms, e.best, e.rv, e.fs, e.to);
                    end
                end
            end
        end
    end

    task automatic push(input string n, input int at, input logic [2:0] st, input logic l,
                        input logic [13:0] ms, input logic [13:0] b,
                        input logic rv, input logic fs, input logic to);
        exp_t x;
        x.name = n; x.at = at; x.st = st; x.led = l; x.ms = ms; x.best = b;
        x.rv = rv; x.fs = fs; x.to = to;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string n, input logic [2:0] s, input int lim);
        int k = 0;
        while (state !== s && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (state !== s) begin
            checks++;
            failures++;
            $display("FAIL %s_wait: got st=%0d, want st=%0d within %0d cycles", n, state, s, lim);
        end
    endtask

    // Called at a negedge; the DELAY entry edge is two clocks after the press.
    task automatic start_run(input string n, input bit hold, input logic [13:0] fs_ms,
                             output int e0, output int d);
        int c = cyc;
        start_btn = 1'b1;
        e0 = c + 2;
        push(n, e0, 3'd1, 1'b0, fs_ms, best_m, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        d = 2 + int'(lfsr_m[1:0]);
        if (!hold) start_btn = 1'b0;
    endtask

    // React acts on edge base+k: sampled at base+k-1, so raised at the negedge after base+k-2.
    task automatic react_at(input int base, input int k);
        while (cyc < base + k - 2) @(negedge clk);
        react_btn = 1'b1;
        tick(2);
        react_btn = 1'b0;
    endtask

    task automatic run_react(input string n, input bit hold, input int k, input logic [13:0] ms);
        int e0, d, go;
        start_run({n, "_delay"}, hold, 14'd0, e0, d);
        go = e0 + 4 * d;
        push({n, "_go"}, go, 3'd2, 1'b1, 14'd0, best_m, 1'b0, 1'b0, 1'b0);
        if (ms < best_m) best_m = ms;
        push({n, "_result"}, go + k, 3'd3, 1'b0, ms, best_m, 1'b1, 1'b0, 1'b0);
        react_at(go, k);
        wait_state(n, 3'd3, 20);
        start_btn = 1'b0;
        tick(3);
    endtask

    initial begin
        int e0, d, go, c;
        rst_n = 1'b0;
        start_btn = 1'b0;
        react_btn = 1'b0;
        tick(3);
        push("reset", 0, 3'd0, 1'b0, 14'd0, 14'd20, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        tick(2);

        // No react: saturates at MAX_MS with timeout, best untouched.
        start_run("to_delay", 1'b0, 14'd0, e0, d);
        go = e0 + 4 * d;
        push("to_go", go, 3'd2, 1'b1, 14'd0, best_m, 1'b0, 1'b0, 1'b0);
        push("timeout", go + 80, 3'd3, 1'b0, 14'd20, 14'd20, 1'b0, 1'b0, 1'b1);
        wait_state("timeout", 3'd3, 4 * d + 100);
        tick(3);

        // Start held high through the whole run must not retrigger.
        run_react("run10", 1'b1, 42, 14'd10);
        run_react("run7", 1'b0, 30, 14'd7);
        run_react("run12", 1'b0, 50, 14'd12);

        // False start during the pre-delay.
        start_run("fs_delay", 1'b0, 14'd0, e0, d);
        push("false_start", e0 + 5, 3'd4, 1'b0, 14'd0, best_m, 1'b0, 1'b1, 1'b0);
        react_at(e0, 5);
        wait_state("false_start", 3'd4, 20);
        tick(2);

        // Restart from FAULT clears the flag; react on the expiry cycle still faults.
        start_run("restart_delay", 1'b0, 14'd0, e0, d);
        push("expiry_fault", e0 + 4 * d, 3'd4, 1'b0, 14'd0, best_m, 1'b0, 1'b1, 1'b0);
        react_at(e0, 4 * d);
        wait_state("expiry_fault", 3'd4, 40);
        tick(2);

        // React coincident with the tick that would make ms_count 6.
        run_react("collide5", 1'b0, 24, 14'd5);

        // Reset mid-GO at ms_count=8.
        start_run("rst_delay", 1'b0, 14'd0, e0, d);
        go = e0 + 4 * d;
        push("rst_go", go, 3'd2, 1'b1, 14'd0, best_m, 1'b0, 1'b0, 1'b0);
        while (cyc < go + 34) @(negedge clk);
        push("mid_reset", go + 35, 3'd0, 1'b0, 14'd0, 14'd20, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        best_m = 14'd20;
        tick(2);

        // Simultaneous start and react in IDLE: start wins.
        c = cyc;
        start_btn = 1'b1;
        react_btn = 1'b1;
        push("start_wins", c + 2, 3'd1, 1'b0, 14'd0, 14'd20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        d = 2 + int'(lfsr_m[1:0]);
        start_btn = 1'b0;
        react_btn = 1'b0;
        go = c + 2 + 4 * d;
        push("sw_go", go, 3'd2, 1'b1, 14'd0, 14'd20, 1'b0, 1'b0, 1'b0);
        best_m = 14'd2;
        push("sw_result", go + 10, 3'd3, 1'b0, 14'd2, 14'd2, 1'b1, 1'b0, 1'b0);
        react_at(go, 10);
        wait_state("sw_result", 3'd3, 20);
        tick(10);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no completion by cycle %0d, want completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
